ahb_manager: RTL and testbench
==============================

// Module: ahb_manager
// PURPOSE
//  AHB-Lite manager (initiator) that turns a simple valid/ready request stream from a core-side
//  requester (fetch/LSU arbiter) into pipelined single NONSEQ transfers on the shared AHB bus.
//  It is the initiating end of the bus that memory_control-style satellites respond to.
//  It returns one in-order response (rdata/err) per accepted request.
//  Address and data phases overlap, so back-to-back zero-wait transfers sustain one per cycle.
// PARAMETERS
//  ADDR_W      32  address width (haddr, req_addr)
//  DATA_W      32  data width (hwdata, hrdata, req_wdata, resp_rdata)
//  CHECK_ALIGN 1   1: misaligned or size==2'b11 requests are failed locally, with no bus access
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted on edge where req_valid & req_ready
//  req_addr    in   ADDR_W  byte address
//  req_write   in   1       1=write, 0=read
//  req_size    in   2       00=byte, 01=half, 10=word
//  req_wdata   in   DATA_W  write data, lane-aligned by requester
//  resp_valid  out  1       one-cycle response pulse
//  resp_rdata  out  DATA_W  read data (0 on write or error)
//  resp_err    out  1       transfer failed (bus hresp or local check)
//  busy        out  1       any transfer in address or data phase
//  haddr       out  ADDR_W  AHB address
//  htrans      out  2       AHB transfer type (IDLE=00, NONSEQ=10 only)
//  hsize       out  2       AHB size
//  hwrite      out  1       AHB write
//  hwdata      out  DATA_W  AHB write data (data phase)
//  hrdata      in   DATA_W  AHB read data
//  hready      in   1       AHB ready (muxed hreadyout)
//  hresp       in   1       AHB error response
// BEHAVIOUR
//  - Two slots. A = address-phase regs driving haddr/htrans/hsize/hwrite.
//    D = data-phase regs {kind: NONE|BUS|LOCERR, write, wdata}.
//  - req_ready = hready (combinational). While hready=0, nothing advances and A outputs hold stable.
//  - Edge with hready=1:
//    - D <= A, where A.htrans=NONSEQ gives BUS, and an A local-fail slot gives LOCERR.
//    - A <= accepted request, or IDLE if there is none.
//  - Local fail (CHECK_ALIGN=1):
//    - Triggers on size==11, size==01 & addr[0], or size==10 & addr[1:0]!=0.
//    - The A slot drives htrans=IDLE but still occupies the slot, so response order is preserved.
//  - Completion: edge with hready=1 and D.kind!=NONE. Next cycle:
//    - resp_valid=1.
//    - resp_err = (kind==LOCERR) | hresp.
//    - resp_rdata = hrdata for a BUS read with hresp=0, else 0.
//  - hwdata = D.wdata while D is a BUS write, else 0.
//  - hsel is not driven here; it is decoded from haddr elsewhere.
//  - Two-cycle error (hresp=1, hready=0 then hresp=1, hready=1):
//    - The manager waits and does not cancel the pending A transfer.
//    - The error is reported at the hready=1 edge.
//  - A single-cycle error (hresp=1 with hready=1) is handled identically.
//  - Latency: request accepted at edge 0, zero waits.
//    - Address phase is cycle 1, data phase is cycle 2, resp_valid is in cycle 3.
//    - Each wait cycle adds 1.
//  - Throughput: 1 response/cycle with continuous req_valid and hready=1.
//  - Simultaneous completion and acceptance on the same edge is the normal pipelined case; no stall.
//  - busy = (A.kind!=NONE) | (D.kind!=NONE).
//  - Reset (async, at any time, including mid-transfer):
//    - A and D are cleared; in-flight transfers are dropped and no response is issued.
//    - htrans=IDLE; haddr, hsize, hwrite and hwdata are 0.
//    - resp_valid, resp_err and resp_rdata are 0; busy=0.
//    - req_ready is forced to 0 while rst=1.
//  - Never emits BUSY or SEQ. hsize/hwrite/haddr are 0 whenever htrans=IDLE.
// TESTING
//  - Read word 0x100, subordinate returns 0xDEADBEEF with zero wait.
//    -> NONSEQ in cycle 1; resp_valid in cycle 3 with rdata=0xDEADBEEF, err=0.
//  - Three back-to-back writes (0x0, 0x4, 0x8), hready=1 throughout.
//    -> hwdata lags haddr by 1 cycle; 3 consecutive resp_valid pulses with err=0.
//  - Read with hready held low for 2 cycles.
//    -> haddr/htrans/hwdata stable during the waits; response 2 cycles later; req_ready=0 while waiting.
//  - Two-cycle error on a write followed by a pending read.
//    -> the write reports err=1; the read still issues and completes with err=0.
//  - Halfword write at 0x3 with CHECK_ALIGN=1, between two valid reads.
//    -> htrans=IDLE in its slot; responses arrive in order: ok, err (rdata=0), ok.
//  - Assert rst while a read is in its data phase.
//    -> outputs immediately at reset values; no resp_valid for that read.

Source files
------------

// File: rtl/ahb_manager.sv
// AHB-Lite manager: converts a valid/ready request stream into pipelined
// single NONSEQ transfers and returns one in-order response per request.
// An address-phase slot (A) and a data-phase slot (D) overlap, so zero-wait
// transfers sustain one per cycle. Misaligned requests are failed locally
// but still pass through both slots, which keeps responses in order.
module ahb_manager #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    // core-side request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    // in-order response stream
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    // AHB-Lite manager side
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [1:0]        hsize,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // What a pipeline slot holds: nothing, a real bus transfer, or a
    // request already failed locally that only needs its error response.
    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_BUS    = 2'd1,
        KIND_LOCERR = 2'd2
    } kind_e;

    // address-phase slot
    kind_e             a_kind;
    logic [ADDR_W-1:0] a_addr;
    logic [1:0]        a_size;
    logic              a_write;
    logic [DATA_W-1:0] a_wdata;

    // data-phase slot
    kind_e             d_kind;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;

    logic req_accept;
    logic req_misaligned;
    logic loc_fail;
    logic a_is_bus;

    // Requests are taken only when the bus pipeline advances; never in reset.
    assign req_ready  = hready & ~rst;
    assign req_accept = req_valid & req_ready;

    // Classify the incoming request as misaligned or unsupported size.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            2'b11:   req_misaligned = 1'b1;
            default: req_misaligned = 1'b0;
        endcase
    end

    assign loc_fail = CHECK_ALIGN & req_misaligned;

    // Address-phase slot: loads the accepted request (or empties) when hready=1.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_kind  <= KIND_NONE;
            a_addr  <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
            a_wdata <= '0;
        end else if (hready) begin
            if (req_accept) begin
                a_kind  <= loc_fail ? KIND_LOCERR : KIND_BUS;
                a_addr  <= req_addr;
                a_size  <= req_size;
                a_write <= req_write;
                a_wdata <= req_wdata;
            end else begin
                a_kind  <= KIND_NONE;
                a_addr  <= '0;
                a_size  <= '0;
                a_write <= 1'b0;
                a_wdata <= '0;
            end
        end
    end

    // Data-phase slot: takes over whatever was in the address phase when hready=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_kind  <= KIND_NONE;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else if (hready) begin
            d_kind  <= a_kind;
            d_write <= a_write;
            d_wdata <= a_wdata;
        end
    end

    // Response register: one-cycle pulse after the data phase completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (hready && (d_kind != KIND_NONE)) begin
            resp_valid <= 1'b1;
            resp_err   <= (d_kind == KIND_LOCERR) | hresp;
            resp_rdata <= ((d_kind == KIND_BUS) && !d_write && !hresp) ? hrdata : '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end
    end

    // Only a real bus transfer is shown on the address bus; all else reads as IDLE with zeros.
    assign a_is_bus = (a_kind == KIND_BUS);
    assign htrans   = a_is_bus ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr    = a_is_bus ? a_addr  : '0;
    assign hsize    = a_is_bus ? a_size  : '0;
    assign hwrite   = a_is_bus ? a_write : 1'b0;
    assign hwdata   = ((d_kind == KIND_BUS) && d_write) ? d_wdata : '0;
    assign busy     = (a_kind != KIND_NONE) | (d_kind != KIND_NONE);

endmodule

// File: tb/tb_ahb_manager.sv
// Directed testbench for ahb_manager. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. The bench plays the
// subordinate by driving hrdata/hready/hresp cycle by cycle.
module tb_ahb_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_manager #(.ADDR_W(32), .DATA_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance to the next cycle's drive point
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic w,
                           input logic [1:0] s, input logic [31:0] d);
        req_valid = v;
        req_addr  = a;
        req_write = w;
        req_size  = s;
        req_wdata = d;
    endtask

    task automatic check_resp(input string tag, input logic v, input logic e, input logic [31:0] d);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'(v));
        check({tag, ".resp_err"},   32'(resp_err),   32'(e));
        check({tag, ".resp_rdata"}, resp_rdata,      d);
    endtask

    task automatic check_addr(input string tag, input logic [1:0] t, input logic [31:0] a, input logic w);
        check({tag, ".htrans"}, 32'(htrans), 32'(t));
        check({tag, ".haddr"},  haddr,       a);
        check({tag, ".hwrite"}, 32'(hwrite), 32'(w));
    endtask

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);

        // ---- reset state ----
        sample();
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check_addr("rst", 2'b00, 32'h0, 1'b0);
        check("rst.hsize",  32'(hsize), 32'd0);
        check("rst.hwdata", hwdata, 32'h0);
        check("rst.busy",   32'(busy), 32'd0);
        check_resp("rst", 1'b0, 1'b0, 32'h0);

        // ---- test 1: word read 0x100, zero wait ----
        next_cycle();
        rst = 1'b0;
        set_req(1'b1, 32'h100, 1'b0, 2'b10, 32'h0);
        sample();
        check("t1.c0.req_ready", 32'(req_ready), 32'd1);
        next_cycle();                                   // cycle 1: address phase
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        sample();
        check_addr("t1.c1", 2'b10, 32'h100, 1'b0);
        check("t1.c1.hsize", 32'(hsize), 32'd2);
        check("t1.c1.busy",  32'(busy), 32'd1);
        check("t1.c1.resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();                                   // cycle 2: data phase
        hrdata = 32'hDEADBEEF;
        sample();
        check_addr("t1.c2", 2'b00, 32'h0, 1'b0);
        check("t1.c2.resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();                                   // cycle 3: response
        hrdata = '0;
        sample();
        check_resp("t1.c3", 1'b1, 1'b0, 32'hDEADBEEF);
        check("t1.c3.busy", 32'(busy), 32'd0);
        next_cycle();
        sample();
        check("t1.c4.resp_valid", 32'(resp_valid), 32'd0);

        // ---- test 2: three back-to-back writes ----
        next_cycle();                                   // cycle 0
        set_req(1'b1, 32'h0, 1'b1, 2'b10, 32'h11111111);
        next_cycle();                                   // cycle 1
        set_req(1'b1, 32'h4, 1'b1, 2'b10, 32'h22222222);
        sample();
        check_addr("t2.c1", 2'b10, 32'h0, 1'b1);
        check("t2.c1.hwdata", hwdata, 32'h0);
        next_cycle();                                   // cycle 2
        set_req(1'b1, 32'h8, 1'b1, 2'b10, 32'h33333333);
        sample();
        check_addr("t2.c2", 2'b10, 32'h4, 1'b1);
        check("t2.c2.hwdata", hwdata, 32'h11111111);
        check("t2.c2.resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();                                   // cycle 3
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        sample();
        check_addr("t2.c3", 2'b10, 32'h8, 1'b1);
        check("t2.c3.hwdata", hwdata, 32'h22222222);
        check_resp("t2.c3", 1'b1, 1'b0, 32'h0);
        next_cycle();                                   // cycle 4
        sample();
        check_addr("t2.c4", 2'b00, 32'h0, 1'b0);
        check("t2.c4.hwdata", hwdata, 32'h33333333);
        check_resp("t2.c4", 1'b1, 1'b0, 32'h0);
        next_cycle();                                   // cycle 5
        sample();
        check("t2.c5.hwdata", hwdata, 32'h0);
        check_resp("t2.c5", 1'b1, 1'b0, 32'h0);
        next_cycle();                                   // cycle 6
        sample();
        check("t2.c6.resp_valid", 32'(resp_valid), 32'd0);

        // ---- test 3: read 0x200 with two wait states, read 0x204 queued ----
        next_cycle();                                   // cycle 0
        set_req(1'b1, 32'h200, 1'b0, 2'b10, 32'h0);
        next_cycle();                                   // cycle 1
        set_req(1'b1, 32'h204, 1'b0, 2'b10, 32'h0);
        sample();
        check_addr("t3.c1", 2'b10, 32'h200, 1'b0);
        next_cycle();                                   // cycle 2: wait 1
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        hready = 1'b0;
        sample();
        check("t3.c2.req_ready", 32'(req_ready), 32'd0);
        check_addr("t3.c2", 2'b10, 32'h204, 1'b0);
        check("t3.c2.hwdata", hwdata, 32'h0);
        next_cycle();                                   // cycle 3: wait 2
        sample();
        check("t3.c3.req_ready", 32'(req_ready), 32'd0);
        check_addr("t3.c3", 2'b10, 32'h204, 1'b0);
        check("t3.c3.resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();                                   // cycle 4: ready
        hready = 1'b1;
        hrdata = 32'hAAAA5555;
        sample();
        check_addr("t3.c4", 2'b10, 32'h204, 1'b0);
        check("t3.c4.resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();                                   // cycle 5
        hrdata = 32'h12345678;
        sample();
        check_resp("t3.c5", 1'b1, 1'b0, 32'hAAAA5555);
        check("t3.c5.htrans", 32'(htrans), 32'd0);
        next_cycle();                                   // cycle 6
        hrdata = '0;
        sample();
        check_resp("t3.c6", 1'b1, 1'b0, 32'h12345678);
        next_cycle();
        sample();
        check("t3.c7.resp_valid", 32'(resp_valid), 32'd0);

        // ---- test 4: two-cycle error on write 0x300, then read 0x304 ----
        next_cycle();                                   // cycle 0
        set_req(1'b1, 32'h300, 1'b1, 2'b10, 32'hCAFE0000);
        next_cycle();                                   // cycle 1
        set_req(1'b1, 32'h304, 1'b0, 2'b10, 32'h0);
        sample();
        check_addr("t4.c1", 2'b10, 32'h300, 1'b1);
        next_cycle();                                   // cycle 2: error, first cycle
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        hready = 1'b0;
        hresp  = 1'b1;
        sample();
        check_addr("t4.c2", 2'b10, 32'h304, 1'b0);
        check("t4.c2.hwdata", hwdata, 32'hCAFE0000);
        next_cycle();                                   // cycle 3: error, second cycle
        hready = 1'b1;
        sample();
        check_addr("t4.c3", 2'b10, 32'h304, 1'b0);
        check("t4.c3.hwdata", hwdata, 32'hCAFE0000);
        next_cycle();                                   // cycle 4
        hresp  = 1'b0;
        hrdata = 32'h0BADF00D;
        sample();
        check_resp("t4.c4", 1'b1, 1'b1, 32'h0);
        check("t4.c4.htrans", 32'(htrans), 32'd0);
        next_cycle();                                   // cycle 5
        hrdata = '0;
        sample();
        check_resp("t4.c5", 1'b1, 1'b0, 32'h0BADF00D);

        // ---- test 5: read 0x400, misaligned half write 0x403, read 0x408 ----
        next_cycle();                                   // cycle 0
        set_req(1'b1, 32'h400, 1'b0, 2'b10, 32'h0);
        next_cycle();                                   // cycle 1
        set_req(1'b1, 32'h403, 1'b1, 2'b01, 32'hBEEF0000);
        sample();
        check_addr("t5.c1", 2'b10, 32'h400, 1'b0);
        next_cycle();                                   // cycle 2
        set_req(1'b1, 32'h408, 1'b0, 2'b10, 32'h0);
        hrdata = 32'h11110000;
        sample();
        check_addr("t5.c2", 2'b00, 32'h0, 1'b0);
        check("t5.c2.hsize", 32'(hsize), 32'd0);
        check("t5.c2.busy",  32'(busy),  32'd1);
        next_cycle();                                   // cycle 3
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        hrdata = 32'hFFFFFFFF;
        sample();
        check_addr("t5.c3", 2'b10, 32'h408, 1'b0);
        check("t5.c3.hwdata", hwdata, 32'h0);
        check_resp("t5.c3", 1'b1, 1'b0, 32'h11110000);
        next_cycle();                                   // cycle 4
        hrdata = 32'h22220000;
        sample();
        check_resp("t5.c4", 1'b1, 1'b1, 32'h0);
        next_cycle();                                   // cycle 5
        hrdata = '0;
        sample();
        check_resp("t5.c5", 1'b1, 1'b0, 32'h22220000);
        next_cycle();
        sample();
        check("t5.c6.busy", 32'(busy), 32'd0);

        // ---- test 6: reset while read 0x500 is in its data phase ----
        next_cycle();                                   // cycle 0
        set_req(1'b1, 32'h500, 1'b0, 2'b10, 32'h0);
        next_cycle();                                   // cycle 1
        set_req(1'b1, 32'h504, 1'b0, 2'b10, 32'h0);
        sample();
        check_addr("t6.c1", 2'b10, 32'h500, 1'b0);
        next_cycle();                                   // cycle 2: data phase of 0x500
        set_req(1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
        hrdata = 32'h55555555;
        #1;
        check("t6.pre.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_addr("t6.rst", 2'b00, 32'h0, 1'b0);
        check("t6.rst.hsize",     32'(hsize),     32'd0);
        check("t6.rst.hwdata",    hwdata,         32'h0);
        check("t6.rst.busy",      32'(busy),      32'd0);
        check("t6.rst.req_ready", 32'(req_ready), 32'd0);
        check_resp("t6.rst", 1'b0, 1'b0, 32'h0);
        next_cycle();                                   // cycle 3: release reset
        rst = 1'b0;
        sample();
        check_resp("t6.c3", 1'b0, 1'b0, 32'h0);
        check("t6.c3.busy", 32'(busy), 32'd0);
        next_cycle();
        hrdata = '0;
        sample();
        check("t6.c4.resp_valid", 32'(resp_valid), 32'd0);
        check("t6.c4.htrans",     32'(htrans),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
